// File: rtl/forth_pkg.sv
// Shared constants for the Forth core: data word width and the 3-bit
// data stack operation encodings.
package forth_pkg;

  localparam int WIDTH    = 16;
  localparam int STK_OP_W = 3;

  localparam logic [STK_OP_W-1:0] STK_NOP   = 3'b000;
  localparam logic [STK_OP_W-1:0] STK_PUSH  = 3'b001;
  localparam logic [STK_OP_W-1:0] STK_POP   = 3'b010;
  localparam logic [STK_OP_W-1:0] STK_UNARY = 3'b011;
  localparam logic [STK_OP_W-1:0] STK_BINOP = 3'b100;
  localparam logic [STK_OP_W-1:0] STK_SWAP  = 3'b101;
  localparam logic [STK_OP_W-1:0] STK_DUP   = 3'b110;
  localparam logic [STK_OP_W-1:0] STK_OVER  = 3'b111;

endpackage : forth_pkg

// File: rtl/stack_ram.sv
// Spill storage for stack entries below N: one synchronous write port and
// one asynchronous read port. Contents are deliberately left unreset.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: spill of N into the slot at the current stack pointer
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : stack_ram

// File: rtl/data_stack.sv
// Forth data stack: T/N registers, spill RAM below N, depth counter, op decode
// and sticky overflow/underflow flags. Offending ops are suppressed entirely.
module data_stack #(
  parameter int WIDTH = forth_pkg::WIDTH,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [PTR_W+1:0] depth,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf
);

  import forth_pkg::*;

  localparam int DW = PTR_W + 2;
  localparam logic [DW-1:0]    D_ZERO  = DW'(0);
  localparam logic [DW-1:0]    D_ONE   = DW'(1);
  localparam logic [DW-1:0]    D_TWO   = DW'(2);
  localparam logic [DW-1:0]    D_THREE = DW'(3);
  localparam logic [DW-1:0]    D_MAX   = DW'(DEPTH + 2);
  localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             empty_q, full_q;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             has1_s, has2_s, has3_s;
  logic [DW-1:0]    sp_s;
  logic [PTR_W-1:0] waddr_s, raddr_s;
  logic [WIDTH-1:0] rdata_s;
  logic [WIDTH-1:0] fill_s;
  logic             we_s, ovf_evt_s, unf_evt_s;

  assign has1_s  = (depth_q != D_ZERO);
  assign has2_s  = (depth_q >= D_TWO);
  assign has3_s  = (depth_q >= D_THREE);
  assign sp_s    = has2_s ? (depth_q - D_TWO) : D_ZERO;
  // sp can reach DEPTH (=16) when full; its low bits minus one still address the top slot
  assign waddr_s = sp_s[PTR_W-1:0];
  assign raddr_s = sp_s[PTR_W-1:0] - P_ONE;
  assign fill_s  = has3_s ? rdata_s : nos_q;

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (we_s),
    .waddr_i(waddr_s),
    .wdata_i(nos_q),
    .raddr_i(raddr_s),
    .rdata_o(rdata_s)
  );

  // Op decode: next T/N/depth, spill enable and error events
  always_comb begin
    tos_d     = tos_q;
    nos_d     = nos_q;
    depth_d   = depth_q;
    we_s      = 1'b0;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    case (op)
      STK_NOP: begin
        depth_d = depth_q;
      end
      STK_PUSH: begin
        if (full_q) begin
          ovf_evt_s = 1'b1;
        end else begin
          we_s    = has2_s;
          nos_d   = tos_q;
          tos_d   = din;
          depth_d = depth_q + D_ONE;
        end
      end
      STK_POP: begin
        if (!has1_s) begin
          unf_evt_s = 1'b1;
        end else begin
          tos_d   = nos_q;
          nos_d   = fill_s;
          depth_d = depth_q - D_ONE;
        end
      end
      STK_UNARY: begin
        if (!has1_s) begin
          unf_evt_s = 1'b1;
        end else begin
          tos_d = alu_res;
        end
      end
      STK_BINOP: begin
        if (!has2_s) begin
          unf_evt_s = 1'b1;
        end else begin
          tos_d   = alu_res;
          nos_d   = fill_s;
          depth_d = depth_q - D_ONE;
        end
      end
      STK_SWAP: begin
        if (!has2_s) begin
          unf_evt_s = 1'b1;
        end else begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
      end
      STK_DUP: begin
        if (!has1_s) begin
          unf_evt_s = 1'b1;
        end else if (full_q) begin
          ovf_evt_s = 1'b1;
        end else begin
          we_s    = has2_s;
          nos_d   = tos_q;
          depth_d = depth_q + D_ONE;
        end
      end
      STK_OVER: begin
        if (!has2_s) begin
          unf_evt_s = 1'b1;
        end else if (full_q) begin
          ovf_evt_s = 1'b1;
        end else begin
          we_s    = 1'b1;
          nos_d   = tos_q;
          tos_d   = nos_q;
          depth_d = depth_q + D_ONE;
        end
      end
      default: begin
        depth_d = depth_q;
      end
    endcase
    // A fresh error in the clearing cycle wins over err_clr
    ovf_d = (ovf_q & ~err_clr) | ovf_evt_s;
    unf_d = (unf_q & ~err_clr) | unf_evt_s;
  end

  // State registers; empty/full are registered from the next depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= D_ZERO;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      empty_q <= (depth_d == D_ZERO);
      full_q  <= (depth_d == D_MAX);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tos     = tos_q;
  assign nos     = nos_q;
  assign depth   = depth_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule : data_stack
